// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - Bricks round clock: loadable countdown with bonus time, warning and expiry
// Two-digit decimal readout; count is kept in binary and split for the display.
module game_countdown_timer #(
  parameter int START_SECS = 99,
  parameter int BONUS_SECS = 10,
  parameter int WARN_SECS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       duty50,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       add_bonus,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       warning,
  output logic       blink,
  output logic       time_up,
  output logic       time_up_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  localparam logic [6:0] START_CNT = 7'(START_SECS);
  localparam logic [7:0] BONUS_ADD = 8'(BONUS_SECS);
  localparam logic [6:0] WARN_CNT  = 7'(WARN_SECS);
  localparam logic [7:0] MAX_CNT   = 8'd99;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       time_up_pulse_q, time_up_pulse_d;

  logic [7:0] bonus_sum;
  logic [7:0] run_sum;
  logic [6:0] bonus_sat;
  logic [6:0] run_sat;

  // 8-bit sums never overflow (99 + 99 < 256); RUN guarantees count >= 1 so the tick cannot underflow.
  always_comb begin
    bonus_sum = {1'b0, count_q} + (add_bonus ? BONUS_ADD : 8'd0);
    run_sum   = bonus_sum - {7'd0, one_sec};
    bonus_sat = (bonus_sum > MAX_CNT) ? 7'd99 : bonus_sum[6:0];
    run_sat   = (run_sum > MAX_CNT) ? 7'd99 : run_sum[6:0];
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    time_up_pulse_d = 1'b0;
    if (load) begin
      state_d = S_IDLE;
      count_d = START_CNT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (START_CNT == 7'd0) begin
              state_d         = S_EXPIRED;
              time_up_pulse_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          // pause takes priority: any tick or bonus in the same cycle is dropped
          if (pause) begin
            state_d = S_PAUSED;
          end else begin
            count_d = run_sat;
            if (one_sec && run_sat == 7'd0) begin
              state_d         = S_EXPIRED;
              time_up_pulse_d = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          count_d = bonus_sat;
          if (!pause) state_d = S_RUN;
        end
        S_EXPIRED: begin
          state_d = S_EXPIRED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= START_CNT;
      time_up_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      time_up_pulse_q <= time_up_pulse_d;
    end
  end

  assign tens          = 4'(count_q / 7'd10);
  assign ones          = 4'(count_q % 7'd10);
  assign running       = (state_q == S_RUN);
  assign time_up       = (state_q == S_EXPIRED);
  assign time_up_pulse = time_up_pulse_q;
  assign warning       = ((state_q == S_RUN) || (state_q == S_PAUSED)) &&
                         (count_q <= WARN_CNT) && (count_q != 7'd0);
  assign blink         = warning & duty50;

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb/tb_game_countdown_timer.sv - directed plus random checks of two timer instances against a behavioural model
module tb_game_countdown_timer;

  localparam int SA = 99, BA = 10, WA = 10;
  localparam int SB = 2,  BB = 3,  WB = 5;

  logic clk = 1'b0;
  logic reset, one_sec, duty50, load, start, pause, add_bonus;

  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic a_running, a_warning, a_blink, a_time_up, a_pulse;
  logic b_running, b_warning, b_blink, b_time_up, b_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_countdown_timer #(.START_SECS(SA), .BONUS_SECS(BA), .WARN_SECS(WA)) dut_a (
    .clk(clk), .reset(reset), .one_sec(one_sec), .duty50(duty50), .load(load),
    .start(start), .pause(pause), .add_bonus(add_bonus), .tens(a_tens), .ones(a_ones),
    .running(a_running), .warning(a_warning), .blink(a_blink), .time_up(a_time_up),
    .time_up_pulse(a_pulse)
  );

  game_countdown_timer #(.START_SECS(SB), .BONUS_SECS(BB), .WARN_SECS(WB)) dut_b (
    .clk(clk), .reset(reset), .one_sec(one_sec), .duty50(duty50), .load(load),
    .start(start), .pause(pause), .add_bonus(add_bonus), .tens(b_tens), .ones(b_ones),
    .running(b_running), .warning(b_warning), .blink(b_blink), .time_up(b_time_up),
    .time_up_pulse(b_pulse)
  );

  // Model: seconds left plus "which phase of the round are we in" flags.
  typedef struct {
    int cnt;
    bit run;
    bit pau;
    bit exp;
    bit pulse;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(int s);
    mdl_t m;
    m.cnt = s; m.run = 0; m.pau = 0; m.exp = 0; m.pulse = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit ld, bit st, bit pz, bit tk, bit bn, int s, int b);
    mdl_t n;
    int v;
    n = m;
    n.pulse = 0;
    if (ld) return mdl_reset(s);
    if (!m.run && !m.pau && !m.exp) begin
      if (st) begin
        if (s == 0) begin n.exp = 1; n.pulse = 1; end
        else n.run = 1;
      end
    end else if (m.run) begin
      if (pz) begin
        n.run = 0; n.pau = 1;
      end else begin
        v = m.cnt - (tk ? 1 : 0) + (bn ? b : 0);
        if (v > 99) v = 99;
        n.cnt = v;
        if (tk && v == 0) begin n.run = 0; n.exp = 1; n.pulse = 1; end
      end
    end else if (m.pau) begin
      if (bn) n.cnt = (m.cnt + b > 99) ? 99 : m.cnt + b;
      if (!pz) begin n.pau = 0; n.run = 1; end
    end
    return n;
  endfunction

  function automatic int exp_warn(mdl_t m, int w);
    return ((m.run || m.pau) && m.cnt <= w && m.cnt != 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic check_all();
    chk("a_tens", int'(a_tens), ma.cnt / 10);
    chk("a_ones", int'(a_ones), ma.cnt % 10);
    chk("a_running", int'(a_running), int'(ma.run));
    chk("a_time_up", int'(a_time_up), int'(ma.exp));
    chk("a_pulse", int'(a_pulse), int'(ma.pulse));
    chk("a_warning", int'(a_warning), exp_warn(ma, WA));
    chk("a_blink", int'(a_blink), exp_warn(ma, WA) & int'(duty50));
    chk("b_tens", int'(b_tens), mb.cnt / 10);
    chk("b_ones", int'(b_ones), mb.cnt % 10);
    chk("b_running", int'(b_running), int'(mb.run));
    chk("b_time_up", int'(b_time_up), int'(mb.exp));
    chk("b_pulse", int'(b_pulse), int'(mb.pulse));
    chk("b_warning", int'(b_warning), exp_warn(mb, WB));
    chk("b_blink", int'(b_blink), exp_warn(mb, WB) & int'(duty50));
  endtask

  task automatic cyc(input bit ld, input bit st, input bit pz, input bit tk, input bit bn, input bit dt);
    load = ld; start = st; pause = pz; one_sec = tk; add_bonus = bn; duty50 = dt;
    @(posedge clk);
    ma = mdl_step(ma, ld, st, pz, tk, bn, SA, BA);
    mb = mdl_step(mb, ld, st, pz, tk, bn, SB, BB);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, i[0]);
  endtask

  initial begin
    bit pz_r;
    reset = 1; one_sec = 0; duty50 = 0; load = 0; start = 0; pause = 0; add_bonus = 0;
    ma = mdl_reset(SA);
    mb = mdl_reset(SB);
    #3;
    check_all();
    @(negedge clk);
    reset = 0;

    // start, 3 ticks: A at 96; B expires on its second tick and stays at 0
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(3);
    chk("tp_a96_tens", int'(a_tens), 9);
    chk("tp_a96_ones", int'(a_ones), 6);
    chk("tp_a96_run", int'(a_running), 1);
    chk("tp_a96_warn", int'(a_warning), 0);
    chk("tp_b_expired", int'(b_time_up), 1);
    chk("tp_b_zero", int'(b_ones), 0);

    // 95 + bonus saturates at 99
    ticks(1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("tp_sat_tens", int'(a_tens), 9);
    chk("tp_sat_ones", int'(a_ones), 9);

    // count 1 with simultaneous tick and bonus -> 10, no expiry
    ticks(98);
    chk("tp_at1_ones", int'(a_ones), 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("tp_tb_tens", int'(a_tens), 1);
    chk("tp_tb_ones", int'(a_ones), 0);
    chk("tp_tb_run", int'(a_running), 1);
    chk("tp_tb_tu", int'(a_time_up), 0);

    // pause holds the count through ticks
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(49);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
    chk("tp_pause_tens", int'(a_tens), 5);
    chk("tp_pause_ones", int'(a_ones), 0);
    chk("tp_pause_run", int'(a_running), 0);
    cyc(0, 0, 0, 0, 0, 0);
    ticks(1);
    chk("tp_resume_tens", int'(a_tens), 4);
    chk("tp_resume_ones", int'(a_ones), 9);

    // warning window and blink following duty50
    ticks(39);
    cyc(0, 0, 0, 0, 0, 1);
    chk("tp_w10_warn", int'(a_warning), 1);
    chk("tp_w10_blink1", int'(a_blink), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("tp_w10_blink0", int'(a_blink), 0);
    ticks(1);
    chk("tp_w9_warn", int'(a_warning), 1);
    ticks(9);
    cyc(0, 0, 0, 0, 0, 1);
    chk("tp_exp_tu", int'(a_time_up), 1);
    chk("tp_exp_warn", int'(a_warning), 0);
    chk("tp_exp_blink", int'(a_blink), 0);

    // asynchronous reset mid-run at 37
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(62);
    chk("tp_at37_tens", int'(a_tens), 3);
    chk("tp_at37_ones", int'(a_ones), 7);
    #2;
    reset = 1;
    ma = mdl_reset(SA);
    mb = mdl_reset(SB);
    #1;
    check_all();
    chk("tp_rst_run", int'(a_running), 0);
    @(negedge clk);
    reset = 0;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("tp_ldst_run", int'(a_running), 0);
    chk("tp_ldst_tu", int'(b_time_up), 0);

    // random traffic against the model
    pz_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) pz_r = ~pz_r;
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0), pz_r,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Consumes the one-second tick (`one_sec`) and half-rate square wave (`duty50`) from the slow-clock generator.
- Runs the Bricks game's round clock: counts down from a loadable start value and accepts bonus-time pulses.
- Produces decimal digits for the 7-segment display, a low-time warning/blink signal and a time-up event for the game controller.

Parameters:
- START_SECS, 99, value loaded on reset/load; legal range 0..99.
- BONUS_SECS, 10, seconds added per add_bonus pulse; legal range 0..99.
- WARN_SECS, 10, warning asserted while count <= this value and count > 0; legal range 0..99.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- one_sec  input  1  single-cycle tick from the slow-clock generator; also the turbo-rate tick when turbo is on.
- duty50  input  1  square wave used for blink.
- load  input  1  pulse: reload START_SECS, go to IDLE.
- start  input  1  pulse: begin countdown.
- pause  input  1  level: hold countdown while high.
- add_bonus  input  1  pulse: add BONUS_SECS.
- tens  output  4  tens digit of count, 0..9.
- ones  output  4  ones digit of count, 0..9.
- running  output  1  high in RUN.
- warning  output  1  low-time indicator.
- blink  output  1  warning AND duty50.
- time_up  output  1  level, high in EXPIRED.
- time_up_pulse  output  1  single-cycle pulse on entry to EXPIRED.

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset is asynchronous and active-high. Port names are `clk` and `reset`.
- State and outputs:
  - Internal count is 7-bit binary, 0..99.
  - tens = count/10 and ones = count%10, combinational from the count register; no added latency.
- Reset value: state IDLE, count = START_SECS, running 0, time_up 0, time_up_pulse 0. warning and blink follow their equations (0 in IDLE).
- States: IDLE, RUN, PAUSED, EXPIRED.
- Transitions, priority per cycle reset > load > start > pause > tick/bonus:
  - load, from any state: count <= START_SECS, go to IDLE.
  - IDLE + start: go to RUN; if START_SECS == 0, go directly to EXPIRED and pulse time_up_pulse.
  - RUN + pause = 1: go to PAUSED. PAUSED + pause = 0: go to RUN. Ticks are ignored in PAUSED.
  - RUN + one_sec:
    - count > 1: count decrements by 1.
    - count == 1: count <= 0, go to EXPIRED, time_up_pulse = 1 on the following cycle only.
  - start in RUN, PAUSED or EXPIRED is ignored.
  - one_sec in IDLE or EXPIRED is ignored.
- Bonus:
  - add_bonus in RUN or PAUSED: count <= min(count + BONUS_SECS, 99). Ignored in IDLE and EXPIRED.
  - Arithmetic uses 8 bits internally before saturation.
- Simultaneous tick and bonus in RUN: count <= min(count - 1 + BONUS_SECS, 99).
  - Expiry occurs only if the result is 0. With count == 1 and BONUS_SECS > 0, no expiry.
- Simultaneous load and start: load wins, ending in IDLE.
- pause asserted on the same cycle as a tick in RUN: pause wins, so the tick is dropped and no decrement occurs.
- time_up = 1 exactly while in EXPIRED. time_up_pulse is registered and never high for two consecutive cycles.
- warning = (state is RUN or PAUSED) AND (count <= WARN_SECS) AND (count != 0). blink = warning AND duty50. Both combinational.
- Reset mid-countdown returns all state to reset values asynchronously; no pending pulse survives.
- Tick width assumption does not apply: a one_sec held high for N cycles decrements N times. Upstream guarantees single-cycle ticks.

Test Plan:
- Reset, start, 3 ticks with START_SECS=99 -> tens=9, ones=6, running=1, warning=0.
- START_SECS=2, start, 2 ticks -> after the 2nd tick count=0 and time_up=1; time_up_pulse high for exactly 1 cycle; further ticks leave count=0.
- count=95, add_bonus with BONUS_SECS=10 -> count=99 (saturated). count=1 with tick and add_bonus on the same cycle -> count=10, no expiry, state stays RUN.
- pause high for 5 ticks at count=50 -> count stays 50 and running=0. Release pause, then 1 tick -> count=49.
- count=10, WARN_SECS=10, duty50 toggling -> warning=1 and blink follows duty50. Tick to 9 -> still warning. At EXPIRED -> warning=0, blink=0.
- Assert reset mid-RUN at count=37 -> count=START_SECS, IDLE, all flags 0 immediately without a clock edge. load and start on the same cycle -> IDLE.
